// File: rtl/iterative_shift_unit.sv
// ---------------------------------------------------------------------------
// iterative_shift_unit
//
// Purpose:
//   Multi-cycle shifter for the MIPS datapath. It moves the operand one bit
//   per clock and covers sll/srl/sra/lui and the variable forms
//   sllv/srlv/srav. The control unit issues an operation with start, stalls
//   while busy is high, and picks up OUT when done pulses.
//
// Handshake:
//   start is sampled only when the unit is idle (IDLE or DONE). A sampled
//   start latches sel, B and the shift amount. busy is high exactly while
//   the unit is shifting (RUN). done is a one-cycle pulse meaning OUT holds
//   a new result. start seen while busy is ignored.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   operation request
//   A            in   n   rs operand; A[SW-1:0] is the variable shift amount
//   B            in   n   rt operand; the value being shifted
//   Shamt        in   SW  instruction shamt field
//   sel          in   3   000 sll, 001 srl, 010 sra, 011 lui,
//                         100 sllv, 101 srlv, 110 srav, 111 pass B
//   busy         out  1   high while shifting
//   done         out  1   one-cycle completion pulse
//   OUT          out  n   result register, held until the next completion
//   o_dbg_state  out  2   current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module iterative_shift_unit #(
    parameter int n  = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [n-1:0]  A,
    input  logic [n-1:0]  B,
    input  logic [SW-1:0] Shamt,
    input  logic [2:0]    sel,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  OUT,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // lui is a fixed half-word left shift.
    localparam logic [SW-1:0] LUI_AMT = SW'(n / 2);

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_op;
    logic [n-1:0]  r_acc;
    logic [SW-1:0] r_cnt;
    logic [n-1:0]  r_out;

    logic          w_load;
    logic [SW-1:0] w_amt;
    logic [n-1:0]  w_shifted;
    logic          w_last;
    logic          w_unused_a;

    // Only the low SW bits of A form the amount; the rest are ignored.
    assign w_unused_a = ^A[n-1:SW];

    // A new operation is accepted only when the unit is not shifting.
    assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // The count reaching one here means this edge produces the final value.
    assign w_last = (r_cnt == SW'(1));

    always_comb begin
        w_amt = '0;
        case (sel)
            3'b000, 3'b001, 3'b010: w_amt = Shamt;
            3'b011:                 w_amt = LUI_AMT;
            3'b100, 3'b101, 3'b110: w_amt = A[SW-1:0];
            default:                w_amt = '0;
        endcase
    end

    always_comb begin
        w_shifted = r_acc;
        case (r_op)
            3'b000, 3'b011, 3'b100: w_shifted = {r_acc[n-2:0], 1'b0};
            3'b001, 3'b101:         w_shifted = {1'b0, r_acc[n-1:1]};
            3'b010, 3'b110:         w_shifted = {r_acc[n-1], r_acc[n-1:1]};
            default:                w_shifted = r_acc;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and state-decoded outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_next = (w_amt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (w_load) begin
                    w_next = (w_amt == '0) ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operands are captured at load so later input changes are
    // invisible to an operation in flight. OUT is written only on the edge
    // that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_out <= '0;
        end else if (w_load) begin
            r_op  <= sel;
            r_acc <= B;
            r_cnt <= w_amt;
            if (w_amt == '0) begin
                r_out <= B;
            end
        end else if (r_state == S_RUN) begin
            r_acc <= w_shifted;
            r_cnt <= r_cnt - SW'(1);
            if (w_last) begin
                r_out <= w_shifted;
            end
        end
    end

    assign OUT         = r_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_iterative_shift_unit
//
// Directed bench for iterative_shift_unit. Inputs are driven on the falling
// edge and outputs sampled on the falling edge, away from the active edge.
// Each operation checks the result, the cycle count to done, the number of
// busy cycles, that OUT holds while shifting, and that done is one cycle.
// ---------------------------------------------------------------------------
module tb_iterative_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic [2:0]  sel;
    logic        busy;
    logic        done;
    logic [31:0] OUT;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int failures = 0;

    iterative_shift_unit #(.n(32), .SW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .Shamt       (Shamt),
        .sel         (sel),
        .busy        (busy),
        .done        (done),
        .OUT         (OUT),
        .o_dbg_state (o_dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to completion. k is the expected
    // amount, so done should appear k+1 falling edges after the start edge.
    task automatic run_op(input string tag, input logic [2:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int k,
                          input logic [31:0] exp);
        int          cyc;
        int          busy_cnt;
        int          hold_bad;
        logic [31:0] out_before;
        @(negedge clk);
        out_before = OUT;
        sel   = s;
        A     = a;
        B     = b;
        Shamt = sh;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        hold_bad = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            if (OUT !== out_before) hold_bad++;
            // Scramble inputs while shifting; the result must not move.
            A     = $urandom;
            B     = $urandom;
            Shamt = 5'($urandom_range(0, 31));
            sel   = 3'($urandom_range(0, 7));
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(k + 1));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(k));
        check({tag, "_out_hold"}, 32'(hold_bad), 32'd0);
        check({tag, "_out"}, OUT, exp);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_out_after"}, OUT, exp);
    endtask

    initial begin
        int          cyc;
        int          seen;
        logic [31:0] first_out;

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Shamt = '0;
        sel   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out", OUT, 32'd0);
        check("reset_state", 32'(o_dbg_state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Main function vectors (amounts and results computed by hand)
        run_op("sll",   3'b000, 32'h0,        32'h00000abc, 5'd6,  6,  32'h0002af00);
        run_op("srl",   3'b001, 32'h0,        32'hffffbbcc, 5'd6,  6,  32'h03fffeef);
        run_op("sra",   3'b010, 32'h0,        32'hffffbbcc, 5'd6,  6,  32'hfffffeef);
        run_op("lui",   3'b011, 32'h0,        32'h0000bbcc, 5'd3,  16, 32'hbbcc0000);
        run_op("lui2",  3'b011, 32'h0,        32'h12345678, 5'd0,  16, 32'h56780000);
        run_op("sllv",  3'b100, 32'hffffffe5, 32'h00000001, 5'd9,  5,  32'h00000020);
        run_op("srlv",  3'b101, 32'h00000023, 32'h000000f0, 5'd0,  3,  32'h0000001e);
        run_op("srav",  3'b110, 32'h0000001f, 32'h80000000, 5'd0,  31, 32'hffffffff);
        run_op("sra_pos", 3'b010, 32'h0,      32'h40000000, 5'd30, 30, 32'h00000001);

        // Zero amount and pass-through
        run_op("sll_zero",  3'b000, 32'h0,        32'h00001234, 5'd0, 0, 32'h00001234);
        run_op("pass",      3'b111, 32'h0,        32'h0000cafe, 5'd5, 0, 32'h0000cafe);
        run_op("sllv_zero", 3'b100, 32'hffffffe0, 32'h00005a5a, 5'd7, 0, 32'h00005a5a);

        // Start pulsed again mid-RUN with new operands: must be ignored.
        @(negedge clk);
        sel = 3'b000; B = 32'h00000abc; Shamt = 5'd6; A = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        sel = 3'b111; B = 32'hdeadbeef; Shamt = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("ignore_latency", 32'(cyc), 32'd7);
        check("ignore_out", OUT, 32'h0002af00);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("ignore_no_extra_done", 32'(seen), 32'd0);
        check("ignore_out_final", OUT, 32'h0002af00);

        // start held through DONE: back-to-back operations, k=3.
        @(negedge clk);
        sel = 3'b000; B = 32'h1; Shamt = 5'd3;
        start = 1'b1;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_latency", 32'(cyc), 32'd4);
        check("b2b_first_out", OUT, 32'h8);
        first_out = OUT;
        B = 32'h3;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("b2b_separation", 32'(cyc), 32'd4);
        check("b2b_second_out", OUT, 32'h18);
        check("b2b_first_was", first_out, 32'h8);
        @(negedge clk);
        check("b2b_idle_done", 32'(done), 32'd0);
        check("b2b_idle_state", 32'(o_dbg_state), 32'd0);

        // Asynchronous reset at RUN cycle 3 of a 20-cycle srav.
        @(negedge clk);
        sel = 3'b110; A = 32'h00000014; B = 32'h80000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_done", 32'(done), 32'd0);
        check("rst_async_out", OUT, 32'd0);
        check("rst_async_state", 32'(o_dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("rst_no_later_activity", 32'(seen), 32'd0);
        check("rst_out_still_zero", OUT, 32'd0);
        run_op("post_rst_srav", 3'b110, 32'h00000014, 32'h80000000, 5'd0, 20, 32'hfffff800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
